// File: rtl/router_pkg.sv
// router_pkg
//   Shared types and constants for the router packet transmitter.
//   - tx_state_t  : transmitter FSM state encoding
//   - ADDR_W/LEN_W/DATA_W : header field and byte widths
//   - pack_header : builds the router header byte {len, addr}
package router_pkg;

  localparam int ADDR_W    = 2;
  localparam int LEN_W     = 6;
  localparam int DATA_W    = 8;
  localparam int BUF_DEPTH = 1 << LEN_W;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_HEADER  = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_PARITY  = 3'd4,
    ST_STATUS  = 3'd5
  } tx_state_t;

  function automatic logic [DATA_W-1:0] pack_header(
    input logic [LEN_W-1:0]  len,
    input logic [ADDR_W-1:0] addr
  );
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// router_tx_buf
//   64x8 payload buffer. Synchronous write at the write pointer,
//   combinational read at the read pointer (and the entry after it, so the
//   transmitter can register the next byte in the same edge it consumes one).
//   Both pointers are cleared whenever a new request is taken.
// Ports:
//   clk, rst          clock, async active-low reset
//   i_clr             clear both pointers
//   i_wr_en/i_wr_data write one byte at o_wr_ptr, then advance
//   i_rd_inc          advance the read pointer
//   o_wr_ptr/o_rd_ptr current pointers
//   o_rd_data         mem[o_rd_ptr]
//   o_rd_data_nxt     mem[o_rd_ptr + 1]
module router_tx_buf
  import router_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_inc,
  output logic [LEN_W-1:0]  o_wr_ptr,
  output logic [LEN_W-1:0]  o_rd_ptr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [DATA_W-1:0] o_rd_data_nxt
);

  logic [DATA_W-1:0] r_mem [BUF_DEPTH];
  logic [LEN_W-1:0]  r_wr_ptr;
  logic [LEN_W-1:0]  r_rd_ptr;
  logic [LEN_W-1:0]  w_rd_ptr_nxt;

  // Storage is a plain register file; stale contents are never read because
  // the transmitter only reads entries written for the current packet.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_wr_en) begin
        r_wr_ptr <= r_wr_ptr + LEN_W'(1);
      end
      if (i_rd_inc) begin
        r_rd_ptr <= r_rd_ptr + LEN_W'(1);
      end
    end
  end

  assign w_rd_ptr_nxt  = r_rd_ptr + LEN_W'(1);
  assign o_wr_ptr      = r_wr_ptr;
  assign o_rd_ptr      = r_rd_ptr;
  assign o_rd_data     = r_mem[r_rd_ptr];
  assign o_rd_data_nxt = r_mem[w_rd_ptr_nxt];

endmodule

// File: rtl/router_pkt_tx.sv
// router_pkt_tx
//   Source side of the router 1x3 input port. Takes a request (addr, len),
//   buffers len payload bytes, then sends header, payload and parity under
//   busy flow control and reports the router's err verdict on done/tx_err.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | req_ready high; bad requests (addr 3, len 0) rejected in place
//   LOAD    | pl_ready high; bytes written to buffer and XORed into parity
//   HEADER  | {len,addr} driven with pkt_valid; held while busy is sampled
//   PAYLOAD | buffer byte rd_ptr driven; consumed on edges with busy low
//   PARITY  | parity byte driven with pkt_valid low; consumed when busy low
//   STATUS  | ERR_WIN cycles collecting err into a sticky flag, then done
//
// Ports:
//   clk, rst                      clock, async active-low reset
//   req_valid/req_ready           request handshake, req_addr/req_len
//   pl_valid/pl_ready/pl_data     payload byte handshake
//   busy, err                     from router
//   pkt_valid, data_out           to router
//   done, tx_err                  completion pulse and held verdict
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int ERR_WIN = 3
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              pl_valid,
  output logic              pl_ready,
  input  logic [DATA_W-1:0] pl_data,
  input  logic              busy,
  input  logic              err,
  output logic              pkt_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              done,
  output logic              tx_err
);

  localparam int              WIN_W    = (ERR_WIN > 1) ? $clog2(ERR_WIN) : 1;
  localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(ERR_WIN - 1);

  tx_state_t         r_state;
  logic              r_req_ready;
  logic              r_pl_ready;
  logic              r_pkt_valid;
  logic [DATA_W-1:0] r_data_out;
  logic              r_done;
  logic              r_tx_err;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [DATA_W-1:0] r_parity;
  logic [WIN_W-1:0]  r_win_cnt;
  logic              r_err_sticky;

  logic              w_req_fire;
  logic              w_req_bad;
  logic              w_pl_fire;
  logic              w_rd_inc;
  logic [LEN_W-1:0]  w_last_idx;
  logic              w_wr_last;
  logic              w_rd_last;
  logic [LEN_W-1:0]  w_wr_ptr;
  logic [LEN_W-1:0]  w_rd_ptr;
  logic [DATA_W-1:0] w_rd_data;
  logic [DATA_W-1:0] w_rd_data_nxt;

  assign w_req_fire = (r_state == ST_IDLE) && req_valid && r_req_ready;
  assign w_req_bad  = (req_addr == 2'd3) || (req_len == '0);
  assign w_pl_fire  = (r_state == ST_LOAD) && pl_valid && r_pl_ready;
  assign w_last_idx = r_len - LEN_W'(1);
  assign w_wr_last  = (w_wr_ptr == w_last_idx);
  assign w_rd_last  = (w_rd_ptr == w_last_idx);
  assign w_rd_inc   = (r_state == ST_PAYLOAD) && !busy && !w_rd_last;

  router_tx_buf u_buf (
    .clk           (clk),
    .rst           (rst),
    .i_clr         (w_req_fire),
    .i_wr_en       (w_pl_fire),
    .i_wr_data     (pl_data),
    .i_rd_inc      (w_rd_inc),
    .o_wr_ptr      (w_wr_ptr),
    .o_rd_ptr      (w_rd_ptr),
    .o_rd_data     (w_rd_data),
    .o_rd_data_nxt (w_rd_data_nxt)
  );

  // data_out is always registered from buffer/parity/header state, so busy
  // only steers which value gets loaded and never reaches data_out directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_req_ready  <= 1'b0;
      r_pl_ready   <= 1'b0;
      r_pkt_valid  <= 1'b0;
      r_data_out   <= '0;
      r_done       <= 1'b0;
      r_tx_err     <= 1'b0;
      r_addr       <= '0;
      r_len        <= '0;
      r_parity     <= '0;
      r_win_cnt    <= '0;
      r_err_sticky <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // req_ready drops for the cycle after any accepted request and
          // otherwise rises one cycle after entering IDLE (after done).
          r_req_ready <= 1'b1;
          if (w_req_fire) begin
            r_req_ready <= 1'b0;
            if (w_req_bad) begin
              r_done   <= 1'b1;
              r_tx_err <= 1'b1;
            end else begin
              r_addr     <= req_addr;
              r_len      <= req_len;
              r_parity   <= pack_header(req_len, req_addr);
              r_pl_ready <= 1'b1;
              r_state    <= ST_LOAD;
            end
          end
        end

        ST_LOAD: begin
          if (w_pl_fire) begin
            r_parity <= r_parity ^ pl_data;
            if (w_wr_last) begin
              r_pl_ready  <= 1'b0;
              r_pkt_valid <= 1'b1;
              r_data_out  <= pack_header(r_len, r_addr);
              r_state     <= ST_HEADER;
            end
          end
        end

        ST_HEADER: begin
          if (!busy) begin
            r_data_out <= w_rd_data;
            r_state    <= ST_PAYLOAD;
          end
        end

        ST_PAYLOAD: begin
          if (!busy) begin
            if (w_rd_last) begin
              r_pkt_valid <= 1'b0;
              r_data_out  <= r_parity;
              r_state     <= ST_PARITY;
            end else begin
              r_data_out <= w_rd_data_nxt;
            end
          end
        end

        ST_PARITY: begin
          if (!busy) begin
            r_data_out   <= '0;
            r_win_cnt    <= WIN_LOAD;
            r_err_sticky <= 1'b0;
            r_state      <= ST_STATUS;
          end
        end

        ST_STATUS: begin
          r_err_sticky <= r_err_sticky | err;
          if (r_win_cnt == '0) begin
            r_done   <= 1'b1;
            r_tx_err <= r_err_sticky | err;
            r_state  <= ST_IDLE;
          end else begin
            r_win_cnt <= r_win_cnt - WIN_W'(1);
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign pl_ready  = r_pl_ready;
  assign pkt_valid = r_pkt_valid;
  assign data_out  = r_data_out;
  assign done      = r_done;
  assign tx_err    = r_tx_err;

endmodule

// File: tb/tb_router_pkt_tx.sv
module tb_router_pkt_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_addr;
  logic [5:0] req_len;
  logic       pl_valid;
  logic       pl_ready;
  logic [7:0] pl_data;
  logic       busy;
  logic       err;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       done;
  logic       tx_err;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] pl_mem [64];

  always #5 clk = ~clk;

  router_pkt_tx #(.ERR_WIN(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .pl_valid  (pl_valid),
    .pl_ready  (pl_ready),
    .pl_data   (pl_data),
    .busy      (busy),
    .err       (err),
    .pkt_valid (pkt_valid),
    .data_out  (data_out),
    .done      (done),
    .tx_err    (tx_err)
  );

  // Issues a request and streams pl_mem[0..n-1]; returns on the negedge
  // where the header should be visible.
  task automatic start_pkt(input logic [1:0] a, input logic [5:0] n);
    int k;
    k = 0;
    while (req_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL req_ready_wait: got %b expected 1", req_ready);
    end
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = n;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < int'(n); i++) begin
      pl_valid = 1'b1;
      pl_data  = pl_mem[i];
      @(negedge clk);
    end
    pl_valid = 1'b0;
  endtask

  // From the parity negedge, steps until done (bounded), raising err for one
  // cycle at step err_at (0 = never). Returns steps taken and tx_err seen.
  task automatic run_status(input int err_at, output int cyc, output logic txe);
    int k;
    for (k = 1; k <= 12; k++) begin
      @(negedge clk);
      err = (k == err_at);
      if (done === 1'b1) break;
    end
    err = 1'b0;
    cyc = k;
    txe = tx_err;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_len = '0;
    pl_valid = 1'b0; pl_data = '0; busy = 1'b0; err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({req_ready, pl_ready, pkt_valid, done, tx_err, data_out} !== 13'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0",
               {req_ready, pl_ready, pkt_valid, done, tx_err, data_out});
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_req_ready: got %b expected 1", req_ready);
    end
  endtask

  task automatic test_basic;
    logic [7:0] ed [4] = '{8'h09, 8'hA5, 8'h3C, 8'h90};
    logic       ev [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    int   cyc;
    logic txe;
    pl_mem[0] = 8'hA5; pl_mem[1] = 8'h3C;
    start_pkt(2'd1, 6'd2);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      vectors++;
      if (data_out !== ed[i] || pkt_valid !== ev[i]) begin
        miscompares++;
        $display("FAIL basic_byte%0d: got %h/%b expected %h/%b", i, data_out, pkt_valid, ed[i], ev[i]);
      end
    end
    run_status(0, cyc, txe);
    vectors++;
    if (cyc !== 4 || txe !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done: got cyc %0d err %b expected cyc 4 err 0", cyc, txe);
    end
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_req_ready_at_done: got %b expected 0", req_ready);
    end
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_after_done: got rdy %b done %b expected 1 0", req_ready, done);
    end
  endtask

  task automatic test_reject;
    logic [1:0] ra [2] = '{2'd3, 2'd2};
    logic [5:0] rl [2] = '{6'd2, 6'd0};
    for (int r = 0; r < 2; r++) begin
      req_valid = 1'b1; req_addr = ra[r]; req_len = rl[r];
      pl_valid = 1'b1; pl_data = 8'hFF;
      @(negedge clk);
      req_valid = 1'b0;
      vectors++;
      if (done !== 1'b1 || tx_err !== 1'b1 || pkt_valid !== 1'b0 || pl_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL reject%0d_done: got done %b err %b pv %b plr %b expected 1 1 0 0",
                 r, done, tx_err, pkt_valid, pl_ready);
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || req_ready !== 1'b1 || pkt_valid !== 1'b0 || pl_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL reject%0d_after: got done %b rdy %b pv %b plr %b expected 0 1 0 0",
                 r, done, req_ready, pkt_valid, pl_ready);
      end
      pl_valid = 1'b0;
    end
  endtask

  task automatic test_header_busy;
    logic [7:0] ed [7] = '{8'h09, 8'h09, 8'h09, 8'h09, 8'hA5, 8'h3C, 8'h90};
    logic       ev [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       eb [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int   cyc;
    logic txe;
    pl_mem[0] = 8'hA5; pl_mem[1] = 8'h3C;
    start_pkt(2'd1, 6'd2);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      vectors++;
      if (data_out !== ed[i] || pkt_valid !== ev[i]) begin
        miscompares++;
        $display("FAIL hdr_busy_cyc%0d: got %h/%b expected %h/%b", i, data_out, pkt_valid, ed[i], ev[i]);
      end
      busy = eb[i];
    end
    run_status(0, cyc, txe);
    vectors++;
    if (cyc !== 4 || txe !== 1'b0) begin
      miscompares++;
      $display("FAIL hdr_busy_done: got cyc %0d err %b expected cyc 4 err 0", cyc, txe);
    end
  endtask

  task automatic test_payload_busy;
    logic [7:0] ed [9] = '{8'h16, 8'h11, 8'h22, 8'h22, 8'h22, 8'h33, 8'h44, 8'h55, 8'h07};
    logic       ev [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       eb [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int   cyc;
    logic txe;
    pl_mem[0] = 8'h11; pl_mem[1] = 8'h22; pl_mem[2] = 8'h33;
    pl_mem[3] = 8'h44; pl_mem[4] = 8'h55;
    start_pkt(2'd2, 6'd5);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      vectors++;
      if (data_out !== ed[i] || pkt_valid !== ev[i]) begin
        miscompares++;
        $display("FAIL pl_busy_cyc%0d: got %h/%b expected %h/%b", i, data_out, pkt_valid, ed[i], ev[i]);
      end
      busy = eb[i];
    end
    @(negedge clk);
    vectors++;
    if (data_out !== 8'h00 || pkt_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL pl_busy_status: got %h/%b expected 00/0", data_out, pkt_valid);
    end
    run_status(0, cyc, txe);
    vectors++;
    if (cyc !== 3 || txe !== 1'b0) begin
      miscompares++;
      $display("FAIL pl_busy_done: got cyc %0d err %b expected cyc 3 err 0", cyc, txe);
    end
  endtask

  task automatic test_err;
    int   cyc;
    logic txe;
    pl_mem[0] = 8'hA5; pl_mem[1] = 8'h3C;
    start_pkt(2'd1, 6'd2);
    repeat (3) @(negedge clk);
    vectors++;
    if (data_out !== 8'h90 || pkt_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL err_parity: got %h/%b expected 90/0", data_out, pkt_valid);
    end
    run_status(2, cyc, txe);
    vectors++;
    if (cyc !== 4 || txe !== 1'b1) begin
      miscompares++;
      $display("FAIL err_done: got cyc %0d err %b expected cyc 4 err 1", cyc, txe);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (tx_err !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL err_hold: got err %b done %b expected 1 0", tx_err, done);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] ed [3] = '{8'h04, 8'h5A, 8'h5E};
    logic       ev [3] = '{1'b1, 1'b1, 1'b0};
    int   cyc;
    logic txe;
    for (int i = 0; i < 63; i++) pl_mem[i] = 8'(8'h40 + i);
    start_pkt(2'd0, 6'd63);
    vectors++;
    if (data_out !== 8'hFC || pkt_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_header: got %h/%b expected FC/1", data_out, pkt_valid);
    end
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (data_out !== 8'h41 || pkt_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_byte1: got %h/%b expected 41/1", data_out, pkt_valid);
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({req_ready, pl_ready, pkt_valid, done, tx_err, data_out} !== 13'h0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: got %h expected 0",
               {req_ready, pl_ready, pkt_valid, done, tx_err, data_out});
    end
    @(negedge clk);
    rst = 1'b1;
    pl_mem[0] = 8'h5A;
    start_pkt(2'd0, 6'd1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      vectors++;
      if (data_out !== ed[i] || pkt_valid !== ev[i]) begin
        miscompares++;
        $display("FAIL post_rst_byte%0d: got %h/%b expected %h/%b", i, data_out, pkt_valid, ed[i], ev[i]);
      end
    end
    run_status(0, cyc, txe);
    vectors++;
    if (cyc !== 4 || txe !== 1'b0) begin
      miscompares++;
      $display("FAIL post_rst_done: got cyc %0d err %b expected cyc 4 err 0", cyc, txe);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reject();
    test_header_busy();
    test_payload_busy();
    test_err();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
